// File: rtl/traffic_pkg.sv
// Shared definitions for the timed junction controller.
//   lamp_t   : lamp drive code (R/Y/G)
//   phase_t  : controller phase, 3-bit encoding exported on the debug port
//   lamps_t  : highway/country lamp pair
//   decode() : phase -> lamp pair; unused codes fall back to all-red
package traffic_pkg;

  typedef enum logic [1:0] {
    LAMP_R = 2'b00,
    LAMP_Y = 2'b01,
    LAMP_G = 2'b10
  } lamp_t;

  typedef enum logic [2:0] {
    HGRN  = 3'd0,
    HYEL  = 3'd1,
    ALLR1 = 3'd2,
    CGRN  = 3'd3,
    CYEL  = 3'd4,
    ALLR2 = 3'd5
  } phase_t;

  typedef struct packed {
    lamp_t h;
    lamp_t c;
  } lamps_t;

  // All-red default keeps the safety invariant even for codes 6/7.
  function automatic lamps_t decode(input phase_t p);
    lamps_t l;
    l = '{h: LAMP_R, c: LAMP_R};
    case (p)
      HGRN:    l = '{h: LAMP_G, c: LAMP_R};
      HYEL:    l = '{h: LAMP_Y, c: LAMP_R};
      CGRN:    l = '{h: LAMP_R, c: LAMP_G};
      CYEL:    l = '{h: LAMP_R, c: LAMP_Y};
      default: l = '{h: LAMP_R, c: LAMP_R};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_phase_timer.sv
// Loadable saturating down-counter that times each controller phase.
//   clock    : system clock, rising edge
//   clear    : async active-high reset, count returns to RST_VAL
//   load     : load load_val this edge (takes priority over decrement)
//   load_val : new count, i.e. phase duration minus one
//   done     : count has reached zero
module traffic_phase_timer #(
  parameter int                CNT_W   = 8,
  parameter logic [CNT_W-1:0]  RST_VAL = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clock or posedge clear) begin
    if (clear)           cnt <= RST_VAL;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/traffic_ctrl_timed.sv
// Highway/country-road junction controller with counter-timed phases.
// Highway green is held for at least H_MIN_GREEN cycles, country green is
// capped at C_MAX_GREEN cycles, and every handover passes yellow then all-red.
//   clock : system clock, rising edge
//   clear : async active-high reset -> HGRN, highway green
//   X     : country-road car sensor (synchronous)
//   H, C  : highway / country lamp codes (R=00, Y=01, G=10), registered
//   phase : current phase code, registered
module traffic_ctrl_timed
  import traffic_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int Y2R_DELAY   = 3,
  parameter int R2G_DELAY   = 2,
  parameter int H_MIN_GREEN = 4,
  parameter int C_MAX_GREEN = 10
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       X,
  output logic [1:0] H,
  output logic [1:0] C,
  output logic [2:0] phase
);

  // Each duration minus one must fit in the timer.
  if (Y2R_DELAY < 1 || Y2R_DELAY > 2**CNT_W) begin : g_bad_y2r
    $error("traffic_ctrl_timed: Y2R_DELAY out of range");
  end
  if (R2G_DELAY < 1 || R2G_DELAY > 2**CNT_W) begin : g_bad_r2g
    $error("traffic_ctrl_timed: R2G_DELAY out of range");
  end
  if (H_MIN_GREEN < 1 || H_MIN_GREEN > 2**CNT_W) begin : g_bad_hmin
    $error("traffic_ctrl_timed: H_MIN_GREEN out of range");
  end
  if (C_MAX_GREEN < 1 || C_MAX_GREEN > 2**CNT_W) begin : g_bad_cmax
    $error("traffic_ctrl_timed: C_MAX_GREEN out of range");
  end

  localparam logic [CNT_W-1:0] LD_Y2R  = CNT_W'(Y2R_DELAY - 1);
  localparam logic [CNT_W-1:0] LD_R2G  = CNT_W'(R2G_DELAY - 1);
  localparam logic [CNT_W-1:0] LD_HMIN = CNT_W'(H_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_CMAX = CNT_W'(C_MAX_GREEN - 1);

  phase_t           state, nxt;
  logic             done, load;
  logic [CNT_W-1:0] load_val;

  always_comb begin
    nxt = state;
    case (state)
      HGRN:    if (done && X)  nxt = HYEL;
      HYEL:    if (done)       nxt = ALLR1;
      ALLR1:   if (done)       nxt = CGRN;
      CGRN:    if (!X || done) nxt = CYEL;
      CYEL:    if (done)       nxt = ALLR2;
      ALLR2:   if (done)       nxt = HGRN;
      default:                 nxt = HGRN;
    endcase
  end

  // Any phase change (including recovery from an illegal code) reloads the
  // timer with the duration of the phase being entered.
  assign load = (nxt != state);

  always_comb begin
    load_val = LD_HMIN;
    case (nxt)
      HGRN:        load_val = LD_HMIN;
      HYEL, CYEL:  load_val = LD_Y2R;
      ALLR1, ALLR2: load_val = LD_R2G;
      CGRN:        load_val = LD_CMAX;
      default:     load_val = LD_HMIN;
    endcase
  end

  traffic_phase_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_HMIN)
  ) u_timer (
    .clock    (clock),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  // Lamps are decoded from the next state so the registered outputs change
  // in the same cycle as the state register.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state  <= HGRN;
      H      <= LAMP_G;
      C      <= LAMP_R;
      phase  <= 3'd0;
    end else begin
      state  <= nxt;
      {H, C} <= decode(nxt);
      phase  <= nxt;
    end
  end

endmodule

// File: tb/tb_traffic_ctrl_timed.sv
module tb_traffic_ctrl_timed;

  logic       clock = 1'b0;
  logic       clear, X, X2;
  logic [1:0] H, C, H2, C2;
  logic [2:0] phase, phase2;

  int total = 0;
  int bad   = 0;

  // reference model: phase index + cycles already spent in that phase
  int m_ph, m_el;   // default-parameter DUT
  int n_ph, n_el;   // short-phase DUT

  always #5 clock = ~clock;

  traffic_ctrl_timed dut (
    .clock (clock), .clear (clear), .X (X),
    .H (H), .C (C), .phase (phase)
  );

  traffic_ctrl_timed #(
    .CNT_W (8), .Y2R_DELAY (1), .R2G_DELAY (1), .H_MIN_GREEN (1), .C_MAX_GREEN (10)
  ) dut2 (
    .clock (clock), .clear (clear), .X (X2),
    .H (H2), .C (C2), .phase (phase2)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // phase lengths: 0 HG, 1 HY, 2 AR, 3 CG, 4 CY, 5 AR
  function automatic int dur(input int ph, input int hmin, input int y2r,
                             input int r2g, input int cmax);
    case (ph)
      0:       return hmin;
      1, 4:    return y2r;
      3:       return cmax;
      default: return r2g;
    endcase
  endfunction

  task automatic model_step(inout int ph, inout int el, input bit x,
                            input int hmin, input int y2r, input int r2g, input int cmax);
    bit expired;
    int n;
    expired = (el >= dur(ph, hmin, y2r, r2g, cmax));
    n = ph;
    case (ph)
      0: if (expired && x)  n = 1;
      3: if (!x || expired) n = 4;
      default: if (expired) n = (ph + 1) % 6;
    endcase
    if (n != ph) begin ph = n; el = 1; end
    else if (el < 1000) el++;
  endtask

  function automatic int lamp_h(input int ph);
    return (ph == 0) ? 2 : (ph == 1) ? 1 : 0;
  endfunction
  function automatic int lamp_c(input int ph);
    return (ph == 3) ? 2 : (ph == 4) ? 1 : 0;
  endfunction

  task automatic compare_all();
    chk("H",      int'(H),      lamp_h(m_ph));
    chk("C",      int'(C),      lamp_c(m_ph));
    chk("phase",  int'(phase),  m_ph);
    chk("H2",     int'(H2),     lamp_h(n_ph));
    chk("C2",     int'(C2),     lamp_c(n_ph));
    chk("phase2", int'(phase2), n_ph);
    chk("safety",  int'(H  != 2'b00 && C  != 2'b00), 0);
    chk("safety2", int'(H2 != 2'b00 && C2 != 2'b00), 0);
  endtask

  // one clock: advance the model on the edge, compare on the falling edge
  task automatic cyc();
    @(posedge clock);
    if (clear) begin
      m_ph = 0; m_el = 1; n_ph = 0; n_el = 1;
    end else begin
      model_step(m_ph, m_el, X,  4, 3, 2, 10);
      model_step(n_ph, n_el, X2, 1, 1, 1, 10);
    end
    @(negedge clock);
    compare_all();
  endtask

  // 0 H=G, 1 H=Y, 2 all-red, 3 C=G, 4 C=Y
  function automatic bit cond(input int m);
    case (m)
      0:       return H == 2'b10;
      1:       return H == 2'b01;
      2:       return H == 2'b00 && C == 2'b00;
      3:       return C == 2'b10;
      default: return C == 2'b01;
    endcase
  endfunction

  task automatic run_len(input int m, output int n);
    n = 0;
    while (cond(m) && n < 60) begin n++; cyc(); end
  endtask

  task automatic wait_cond(input string tag, input int m);
    int n = 0;
    while (!cond(m) && n < 60) begin n++; cyc(); end
    chk(tag, int'(cond(m)), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clear = 1'b1; X = 1'b0; X2 = 1'b0;
    m_ph = 0; m_el = 1; n_ph = 0; n_el = 1;

    // async reset before any clock edge
    #2;
    chk("rst_H", int'(H), 2);
    chk("rst_C", int'(C), 0);
    chk("rst_phase", int'(phase), 0);
    // clear held across edges
    cyc(); cyc();
    clear = 1'b0;

    // 1: no traffic
    repeat (30) cyc();

    // 2: X from release
    clear = 1'b1; cyc();
    clear = 1'b0; X = 1'b1;
    run_len(0, n); chk("t2_hgrn_len", n, 4);
    run_len(1, n); chk("t2_hyel_len", n, 3);
    run_len(2, n); chk("t2_allr_len", n, 2);
    chk("t2_cgrn_at_9", int'(C), 2);

    // 3: X held -> country green timeout, then highway minimum green
    run_len(3, n); chk("t3_cgrn_len", n, 10);
    run_len(4, n); chk("t3_cyel_len", n, 3);
    run_len(2, n); chk("t3_allr_len", n, 2);
    run_len(0, n); chk("t3_hgrn_min", n, 4);

    // 4: X drops in country green cycle 5
    wait_cond("t4_reach_cgrn", 3);
    n = 0;
    repeat (4) begin if (cond(3)) n++; cyc(); end
    if (cond(3)) n++;
    X = 1'b0;
    cyc();
    chk("t4_cgrn_len", n, 5);
    chk("t4_cyel_next", int'(C), 1);

    // 5: clear between edges during country yellow
    #2 clear = 1'b1;
    #1;
    chk("t5_async_H", int'(H), 2);
    chk("t5_async_C", int'(C), 0);
    chk("t5_async_phase", int'(phase), 0);
    cyc();
    clear = 1'b0; X = 1'b1;
    run_len(0, n); chk("t5_hgrn_len", n, 4);
    run_len(1, n); chk("t5_hyel_len", n, 3);
    run_len(2, n); chk("t5_allr_len", n, 2);
    chk("t5_cgrn", int'(C), 2);

    // 6: one-cycle phases on the short DUT
    X2 = 1'b1;
    cyc(); chk("t6_hyel", int'(phase2), 1);
    cyc(); chk("t6_allr1", int'(phase2), 2);
    cyc(); chk("t6_cgrn", int'(phase2), 3);

    // random sensor traffic on both DUTs; model and safety checked every cycle
    repeat (1000) begin
      X  = ($urandom_range(0, 3) != 0);
      X2 = ($urandom_range(0, 1) != 0);
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
